ddr_burst_sched: RTL and testbench

DDR_BURST_SCHED -- requirements
Module: ddr_burst_sched

---
 rtl/ddr_burst_sched_pkg.sv | 20 ++
 rtl/ddr_burst_sched_fold_fifo.sv | 59 +++++
 rtl/ddr_burst_sched.sv | 117 +++++++++++
 tb/tb_ddr_burst_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_burst_sched_pkg.sv
// Shared types and constants for the DDR burst scheduler: FSM states,
// default FIFO depth, fold width and the beat folding function.
package ddr_burst_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int DEFAULT_DEPTH = 4;
    localparam int FOLD_W        = 8;

    // XOR of all four bytes of the DDR beat (hi and lo half-words).
    function automatic logic [FOLD_W-1:0] fold_beat(input logic [15:0] hi, input logic [15:0] lo);
        return hi[15:8] ^ hi[7:0] ^ lo[15:8] ^ lo[7:0];
    endfunction

endpackage

// File: rtl/ddr_burst_sched_fold_fifo.sv
// Small synchronous FIFO for folded beats; a push into a full FIFO is
// accepted only when a pop happens on the same cycle.
module ddr_fold_fifo
    import ddr_burst_sched_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [FOLD_W-1:0] push_data,
    input  logic              pop,
    output logic [FOLD_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FOLD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              wr_en;
    logic              rd_en;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr_burst_sched.sv
// Burst scheduler: arms the DDR capture flops, folds len beats into a FIFO
// and a running checksum, then drains the FIFO and pulses done.
module ddr_burst_sched
    import ddr_burst_sched_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              abort,
    input  logic [15:0]       lo_word,
    input  logic [15:0]       hi_word,
    output logic              cap_en,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FOLD_W-1:0] out_data,
    output logic              done,
    output logic [FOLD_W-1:0] csum,
    output logic              ovf
);

    state_t            state;
    state_t            state_next;
    logic [7:0]        len_q;
    logic [8:0]        beat_cnt;
    logic [8:0]        beat_target;
    logic              last_beat;
    logic              take;
    logic              flush;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FOLD_W-1:0] fifo_head;
    logic [FOLD_W-1:0] beat_fold;

    assign beat_fold   = fold_beat(hi_word, lo_word);
    // len of 0 encodes 256: the zero flag becomes bit 8 of the target.
    assign beat_target = {(len_q == 8'd0), len_q};
    assign last_beat   = ((beat_cnt + 9'd1) == beat_target);
    assign busy        = (state != IDLE);
    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_empty ? '0 : fifo_head;
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cap_en     = 1'b0;
        done       = 1'b0;
        take       = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE:    if (start) state_next = ARM;
            ARM: begin
                cap_en     = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                cap_en = 1'b1;
                take   = 1'b1;
                if (last_beat) state_next = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything: no beat, no done, FIFO cleared.
        if (abort && state != IDLE) begin
            state_next = IDLE;
            take       = 1'b0;
            done       = 1'b0;
            flush      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            beat_cnt <= '0;
            csum     <= '0;
            ovf      <= 1'b0;
        end else if (state == IDLE && start) begin
            len_q    <= len;
            beat_cnt <= '0;
            csum     <= '0;
            ovf      <= 1'b0;
        end else if (take) begin
            beat_cnt <= beat_cnt + 9'd1;
            csum     <= csum ^ beat_fold;
            if (fifo_full && !pop) ovf <= 1'b1;
        end
    end

    ddr_fold_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (take),
        .push_data (beat_fold),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Directed testbench for ddr_burst_sched with hand-computed expectations.
module tb_ddr_burst_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic [15:0] lo_word;
    logic [15:0] hi_word;
    logic        cap_en;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        done;
    logic [7:0]  csum;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    ddr_burst_sched #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .lo_word   (lo_word),
        .hi_word   (hi_word),
        .cap_en    (cap_en),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done),
        .csum      (csum),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".cap_en"},    32'(cap_en),    32'h0);
        check({tag, ".busy"},      32'(busy),      32'h0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'h0);
        check({tag, ".out_data"},  32'(out_data),  32'h0);
        check({tag, ".done"},      32'(done),      32'h0);
        check({tag, ".csum"},      32'(csum),      32'h0);
        check({tag, ".ovf"},       32'(ovf),       32'h0);
    endtask

    initial begin
        int cap_cnt;
        int pops;
        int bad;
        int cyc;

        rst = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
        lo_word = 16'h0; hi_word = 16'h0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single beat
        start = 1'b1; len = 8'd1; hi_word = 16'h1234; lo_word = 16'h0F0F; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("t1.arm_busy",  32'(busy),      32'h1);
        check("t1.arm_capen", 32'(cap_en),    32'h1);
        check("t1.arm_valid", 32'(out_valid), 32'h0);
        tick();
        check("t1.cap_capen", 32'(cap_en),    32'h1);
        check("t1.cap_valid", 32'(out_valid), 32'h0);
        tick();
        check("t1.valid",     32'(out_valid), 32'h1);
        check("t1.data",      32'(out_data),  32'h26);
        check("t1.capen_off", 32'(cap_en),    32'h0);
        check("t1.done_early",32'(done),      32'h0);
        tick();
        check("t1.done",      32'(done),      32'h1);
        check("t1.csum",      32'(csum),      32'h26);
        check("t1.ovf",       32'(ovf),       32'h0);
        tick();
        check("t1.done_pulse",32'(done),      32'h0);
        check("t1.idle",      32'(busy),      32'h0);
        check("t1.csum_hold", 32'(csum),      32'h26);

        // Backpressure: 6 beats into a 4-deep FIFO with no pops
        out_ready = 1'b0; lo_word = 16'h0;
        start = 1'b1; len = 8'd6;
        tick();
        start = 1'b0;
        tick();
        for (int i = 1; i <= 6; i++) begin
            hi_word = {8'(i), 8'h00};
            tick();
        end
        check("t2.ovf",   32'(ovf),      32'h1);
        check("t2.csum",  32'(csum),     32'h07);
        check("t2.valid", 32'(out_valid),32'h1);
        check("t2.head",  32'(out_data), 32'h01);
        check("t2.capen", 32'(cap_en),   32'h0);
        check("t2.nodone",32'(done),     32'h0);
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        check("t2.start_ignored_busy", 32'(busy),     32'h1);
        check("t2.head_stable",        32'(out_data), 32'h01);
        check("t2.nodone2",            32'(done),     32'h0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t2.pop%0d", k), 32'(out_data), 32'(k));
            check($sformatf("t2.pop%0d_nodone", k), 32'(done), 32'h0);
            tick();
        end
        check("t2.done",     32'(done),      32'h1);
        check("t2.csum_end", 32'(csum),      32'h07);
        check("t2.empty",    32'(out_valid), 32'h0);
        tick();
        check("t2.idle",     32'(busy),      32'h0);
        check("t2.ovf_hold", 32'(ovf),       32'h1);

        // Full FIFO with simultaneous push and pop on the 5th beat
        out_ready = 1'b0;
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        check("t3.ovf_cleared", 32'(ovf), 32'h0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            hi_word = {8'(i), 8'h00};
            out_ready = (i == 5);
            tick();
        end
        check("t3.ovf", 32'(ovf),  32'h0);
        check("t3.csum",32'(csum), 32'h01);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("t3.pop%0d", k), 32'(out_data), 32'(k));
            tick();
        end
        check("t3.done", 32'(done), 32'h1);
        tick();

        // Abort at beat 3 of len=8
        out_ready = 1'b0;
        start = 1'b1; len = 8'd8;
        tick();
        start = 1'b0;
        tick();
        for (int i = 1; i <= 2; i++) begin
            hi_word = {8'(i), 8'h00};
            tick();
        end
        check("t4.valid_before", 32'(out_valid), 32'h1);
        hi_word = 16'h0300; abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("t4.idle",  32'(busy),      32'h0);
        check("t4.capen", 32'(cap_en),    32'h0);
        check("t4.valid", 32'(out_valid), 32'h0);
        check("t4.done",  32'(done),      32'h0);
        tick();
        check("t4.done_after", 32'(done), 32'h0);
        check("t4.still_idle", 32'(busy), 32'h0);

        // Length 0 means 256 beats; every fold is zero
        out_ready = 1'b1; hi_word = 16'h0001; lo_word = 16'h0001;
        start = 1'b1; len = 8'd0;
        @(posedge clk);
        #1 check("t5.arm_capen", 32'(cap_en), 32'h1);
        @(negedge clk);
        start = 1'b0;
        cap_cnt = 0; pops = 0; bad = 0; cyc = 0;
        while (!done && cyc < 400) begin
            if (cap_en) cap_cnt++;
            if (out_valid) begin
                pops++;
                if (out_data != 8'h00) bad++;
            end
            tick();
            cyc++;
        end
        check("t5.done",     32'(done),    32'h1);
        check("t5.cap_cyc",  32'(cap_cnt), 32'd257);
        check("t5.pops",     32'(pops),    32'd256);
        check("t5.bad_data", 32'(bad),     32'd0);
        check("t5.csum",     32'(csum),    32'h00);
        check("t5.ovf",      32'(ovf),     32'h0);
        tick();

        // Reset in CAPTURE
        out_ready = 1'b0; hi_word = 16'h5A00; lo_word = 16'h0;
        start = 1'b1; len = 8'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("t6.pre_valid", 32'(out_valid), 32'h1);
        check("t6.pre_capen", 32'(cap_en),    32'h1);
        #2 rst = 1'b1;
        #1 check_all_zero("t6.async");
        @(negedge clk);
        check_all_zero("t6.held");
        rst = 1'b0; start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        check("t6.first_start", 32'(busy), 32'h1);
        check("t6.first_capen", 32'(cap_en), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("t6.nodone%0d", j), 32'(done), 32'h0);
            check($sformatf("t6.idle%0d", j),   32'(busy), 32'h0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
